// File: rtl/regfile_wb_sched_if.sv
// Write-back bus between issue stage, result producers and the register file write port.
interface regfile_wb_sched_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Handshake: a producer raises valid with stable addr/data and holds all three
    // until it sees ready high in the same cycle; valid && ready is the transfer.
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic              iss_ready;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              rs_busy;
    logic              rt_busy;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              md_valid;
    logic [ADDR_W-1:0] md_addr;
    logic [DATA_W-1:0] md_data;
    logic              md_ready;

    logic              rf_wen;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output iss_valid, iss_addr, rs_addr, rt_addr,
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output md_valid, md_addr, md_data,
        input  iss_ready, rs_busy, rt_busy,
        input  alu_ready, mem_ready, md_ready,
        input  rf_wen, rf_waddr, rf_wdata
    );

    modport slave (
        input  iss_valid, iss_addr, rs_addr, rt_addr,
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  md_valid, md_addr, md_data,
        output iss_ready, rs_busy, rt_busy,
        output alu_ready, mem_ready, md_ready,
        output rf_wen, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Round-robin write-back arbiter for the register file write port, plus the
// pending-write scoreboard the issue stage uses for RAW/WAW stalls.
module regfile_wb_sched #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic               clk,
    input logic               reset,
    regfile_wb_sched_if.slave bus
);
    localparam int         NREG    = 1 << ADDR_W;
    localparam logic [1:0] IDX_ALU = 2'd0;
    localparam logic [1:0] IDX_MEM = 2'd1;
    localparam logic [1:0] IDX_MD  = 2'd2;

    logic [NREG-1:0]   sb;
    logic [NREG-1:0]   sb_next;
    logic [1:0]        last;
    logic [2:0]        req;
    logic [2:0]        cand_sum;
    logic              gnt_any;
    logic [1:0]        gnt_idx;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic              wen_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              iss_fire;

    assign req = {bus.md_valid, bus.mem_valid, bus.alu_valid};

    // sb[0] is held at zero, so indexing directly gives busy(0) = 0.
    assign bus.rs_busy   = sb[bus.rs_addr];
    assign bus.rt_busy   = sb[bus.rt_addr];
    assign bus.iss_ready = !reset && !sb[bus.iss_addr];
    assign iss_fire      = bus.iss_valid && bus.iss_ready && (bus.iss_addr != '0);

    // Search last+1, last+2, last (mod 3); first valid requester wins.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = last;
        cand_sum = '0;
        for (int k = 1; k <= 3; k++) begin
            cand_sum = {1'b0, last} + 3'(k);
            if (cand_sum >= 3'd3) cand_sum = cand_sum - 3'd3;
            if (!gnt_any && req[cand_sum[1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_sum[1:0];
            end
        end
        if (reset) gnt_any = 1'b0;
    end

    always_comb begin
        gnt_addr = bus.alu_addr;
        gnt_data = bus.alu_data;
        case (gnt_idx)
            IDX_MEM: begin
                gnt_addr = bus.mem_addr;
                gnt_data = bus.mem_data;
            end
            IDX_MD: begin
                gnt_addr = bus.md_addr;
                gnt_data = bus.md_data;
            end
            default: ;
        endcase
    end

    assign bus.alu_ready = gnt_any && (gnt_idx == IDX_ALU);
    assign bus.mem_ready = gnt_any && (gnt_idx == IDX_MEM);
    assign bus.md_ready  = gnt_any && (gnt_idx == IDX_MD);

    // Gating with reset keeps a write registered just before reset from committing.
    assign bus.rf_wen   = wen_q && !reset;
    assign bus.rf_waddr = waddr_q;
    assign bus.rf_wdata = wdata_q;

    always_comb begin
        sb_next = sb;
        if (bus.rf_wen) sb_next[waddr_q] = 1'b0;
        if (iss_fire) sb_next[bus.iss_addr] = 1'b1;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb      <= '0;
            last    <= IDX_MD;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            sb <= sb_next;
            if (gnt_any) begin
                last    <= gnt_idx;
                wen_q   <= (gnt_addr != '0);
                waddr_q <= gnt_addr;
                wdata_q <= gnt_data;
            end else begin
                wen_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler and scoreboard for the 32x32 register file. It arbitrates the single register-file write port among three result sources with valid/ready handshakes: ALU, load unit and multiply/divide unit. It also tracks which destination registers have an outstanding write, so the issue stage can stall on RAW and WAW hazards. It sits between the execute/memory units and the register file's `wen`/`write_addr`/`write_data` inputs.

## Interface
- DATA_W, 32, result data width
- ADDR_W, 5, register address width (32 registers)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- iss_valid  in  1  issue stage requests to reserve a destination register
- iss_addr  in  ADDR_W  destination register to reserve
- iss_ready  out  1  reservation accepted this cycle
- rs_addr, rt_addr  in  ADDR_W  source registers of the instruction in issue
- rs_busy, rt_busy  out  1  source register has a pending write
- alu_valid, mem_valid, md_valid  in  1  requester has a result
- alu_addr, mem_addr, md_addr  in  ADDR_W  result destination
- alu_data, mem_data, md_data  in  DATA_W  result value
- alu_ready, mem_ready, md_ready  out  1  result granted this cycle
- rf_wen  out  1  register file write enable
- rf_waddr  out  ADDR_W  register file write address
- rf_wdata  out  DATA_W  register file write data

## Operation
- Scoreboard: 32-bit vector `sb`. Bit 0 is hardwired to 0.
- busy(a) = sb[a] for a≠0, and 0 for a=0. rs_busy/rt_busy/iss_ready are combinational from sb and the addresses.
- iss_ready = !busy(iss_addr) && !reset. This stalls WAW.
- On iss_valid && iss_ready with iss_addr≠0: set sb[iss_addr] at the clock edge. Issue to $0 is accepted with no effect.
- Arbitration is round-robin over requester indices ALU=0, MEM=1, MD=2.
  - Pointer `last` holds the index of the last granted requester.
  - Priority order is last+1, last+2, last (mod 3).
  - At most one ready per cycle. Ready is combinational from the valids and `last`, and is forced to 0 during reset.
  - `last` updates to the granted index only when a grant occurs.
- Requesters hold valid, addr and data stable until ready is seen. Valid must not be withdrawn before ready.
- A granted result is registered into rf_waddr/rf_wdata.
  - rf_wen is set to 1 in the next cycle if the granted addr≠0.
  - If the granted addr=0, rf_wen=0 and the grant is still consumed, so ready=1.
- Scoreboard clear: when rf_wen=1, sb[rf_waddr] is cleared at the end of that cycle, on the same edge the register file commits the write.
- A set and a clear in the same cycle always target different registers, because an issue to a busy register is refused. Both take effect.
- A write to a register whose sb bit is not set proceeds normally and leaves sb unchanged.
- No bypass: busy stays 1 until the register file holds the new value.

## Timing
- Reset values:
  - sb = 0, last = 2 (ALU has first priority)
  - rf_wen = 0, rf_waddr = 0, rf_wdata = 0
  - all ready outputs 0 while reset is high
  - iss_ready = 0 while reset is high
- Grant in cycle N → rf_wen/rf_waddr/rf_wdata valid in cycle N+1 → register file written at the end of N+1 → busy deasserts in N+2.
- Issue accepted in cycle N → busy(iss_addr)=1 from cycle N+1.
- Throughput is one write-port grant per cycle. The output stage never back-pressures.
- With all three requesters continuously valid, each is granted once every 3 cycles. Worst-case wait is 2 cycles.
- Reset mid-operation:
  - all reservations are dropped and any grant in that cycle is cancelled
  - an rf_wen already registered is cleared; the write in flight at the reset edge is not performed
  - requesters must re-present after reset

## Test plan
- Reserve, then read: reset; iss_valid=1, iss_addr=5 → iss_ready=1. Next cycle, rs_addr=5 → rs_busy=1, rt_addr=0 → rt_busy=0. Then iss_addr=5 again → iss_ready=0.
- Single write latency: after reserving r5, alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF in cycle N → alu_ready=1 in N; rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF in N+1; rs_busy(5)=0 in N+2.
- Round-robin: alu/mem/md all valid continuously with addrs 1/2/3, starting right after reset → grant sequence ALU, MEM, MD, ALU, MEM, MD. rf_waddr sequence 1, 2, 3, 1… one cycle later.
- Register zero: md_valid=1, md_addr=0, md_data=0x12345678 → md_ready=1 and rf_wen stays 0. iss_addr=0 → iss_ready=1 and rs_busy(0) stays 0.
- Concurrent set/clear: r7 write committing (rf_wen=1, rf_waddr=7) while issuing r9 → next cycle busy(7)=0 and busy(9)=1.
- Reset mid-operation: reserve r4 and r6, grant a write to r4, assert reset in the following cycle → rf_wen=0, all busy=0, no ready asserted during reset. After release, ALU wins the first contention.
